// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter_pkg
// Shared widths, the aux queue entry record and the arbiter state encoding
// used by the write-back arbiter, its aux queue and its bus interface.
package wb_write_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  // One buffered second-destination write. valid drops when a younger
  // pipeline write to the same register makes the entry obsolete.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              valid;
  } wb_entry_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if
// Bundles the MEM/WB slot, the aux requester, the register-file write port,
// the output port and the stall back to the pipeline.
//   slave  : the arbiter side (takes pipeline/aux inputs, drives RF/port/stall)
//   master : the surrounding pipeline side
interface wb_write_arbiter_if;
  import wb_write_arbiter_pkg::*;

  logic              p_valid;
  logic [DATA_W-1:0] p_load;
  logic [DATA_W-1:0] p_result;
  logic              p_wb_sel;
  logic              p_reg_write;
  logic              p_port_write;
  logic [ADDR_W-1:0] p_rd;

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic [ADDR_W-1:0] a_rd;
  logic              a_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [DATA_W-1:0] out_port;
  logic              out_port_strobe;
  logic              stall;

  modport slave (
    input  p_valid, p_load, p_result, p_wb_sel, p_reg_write, p_port_write, p_rd,
    input  a_valid, a_data, a_rd,
    output a_ready, rf_we, rf_waddr, rf_wdata, out_port, out_port_strobe, stall
  );

  modport master (
    output p_valid, p_load, p_result, p_wb_sel, p_reg_write, p_port_write, p_rd,
    output a_valid, a_data, a_rd,
    input  a_ready, rf_we, rf_waddr, rf_wdata, out_port, out_port_strobe, stall
  );

endinterface

// File: rtl/wb_write_arbiter_aux_fifo.sv
// wb_aux_fifo
// Small FIFO of aux register writes with per-entry valid bits.
//   push/push_rd/push_data : enqueue (caller guarantees ~full)
//   pop                    : consume the head (caller guarantees head_valid)
//   squash_en/squash_rd    : invalidate every stored entry targeting squash_rd
//   full, head_valid, head_rd, head_data : queue status and head contents
// An invalidated entry that reaches the head is discarded on its own, without
// the caller seeing it; until then it keeps its slot.
module wb_aux_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              squash_en,
  input  logic [ADDR_W-1:0] squash_rd,
  output logic              full,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_rd,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             non_empty;
  logic             drop;
  logic             advance;

  assign non_empty  = (count != '0);
  assign full       = (count == CNT_W'(QDEPTH));
  assign head_valid = non_empty & mem[rd_ptr].valid;
  assign head_rd    = mem[rd_ptr].rd;
  assign head_data  = mem[rd_ptr].data;
  // A squashed head leaves silently the cycle after it was invalidated.
  assign drop       = non_empty & ~mem[rd_ptr].valid;
  assign advance    = pop | drop;

  // Storage, pointers and occupancy. The squash loop runs before the push so
  // a freshly written slot always ends up valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (squash_en && (mem[i].rd == squash_rd)) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (push) begin
        mem[wr_ptr] <= '{rd: push_rd, data: push_data, valid: 1'b1};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (advance) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, advance})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// End-of-pipeline owner of the single register-file write port and the
// registered output port.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of wb_write_arbiter_if (MEM/WB slot, aux requests,
//              RF write port, output port + strobe, stall)
// The pipeline normally wins the RF port; buffered aux writes fill idle
// cycles. A head that waits STARVE_MAX cycles earns one forced write cycle
// during which the pipeline is stalled.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_write_arbiter_if.slave bus
);

  localparam int               AGE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [AGE_W-1:0]  age;
  logic              stall_q;
  logic              pw;
  logic              port_wr;
  logic              aux_push;
  logic              aux_full;
  logic              head_valid;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] wb_data;
  logic              pop;
  logic              squash_head;
  logic              starving;

  // Stall comes straight from the state register so no input reaches it.
  assign stall_q = (state == ST_FORCE);
  assign wb_data = bus.p_wb_sel ? bus.p_load : bus.p_result;
  assign pw      = bus.p_valid & bus.p_reg_write & ~bus.p_port_write & ~stall_q;
  assign port_wr = bus.p_valid & bus.p_port_write & ~stall_q;

  // Aux writes are program-older than the retiring instruction, so a request
  // to the register being written now is accepted but thrown away.
  assign bus.a_ready = ~aux_full;
  assign aux_push    = bus.a_valid & ~aux_full & ~(pw & (bus.a_rd == bus.p_rd));

  assign squash_head = pw & head_valid & (head_rd == bus.p_rd);
  assign starving    = head_valid & ~pop & ~squash_head;

  wb_aux_fifo #(
    .QDEPTH (QDEPTH)
  ) u_aux_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (aux_push),
    .push_rd    (bus.a_rd),
    .push_data  (bus.a_data),
    .pop        (pop),
    .squash_en  (pw),
    .squash_rd  (bus.p_rd),
    .full       (aux_full),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // FORCE is entered only if the starved head is still waiting this cycle,
  // which guarantees the forced cycle has a valid head to write.
  always_comb begin
    state_next = state;
    case (state)
      ST_NORMAL: if ((age == AGE_MAX) && starving) state_next = ST_FORCE;
      ST_FORCE:  state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  // RF port arbitration: forced head, then pipeline, then any waiting head.
  always_comb begin
    bus.stall    = stall_q;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    pop          = 1'b0;
    if (stall_q) begin
      bus.rf_we    = head_valid;
      bus.rf_waddr = head_rd;
      bus.rf_wdata = head_data;
      pop          = head_valid;
    end else if (pw) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.p_rd;
      bus.rf_wdata = wb_data;
    end else if (head_valid) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = head_rd;
      bus.rf_wdata = head_data;
      pop          = 1'b1;
    end
  end

  // Age of the current head; restarts whenever the head changes or leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (!starving) begin
      age <= '0;
    end else if (age != AGE_MAX) begin
      age <= age + AGE_W'(1);
    end
  end

  // Output port register and its one-cycle update strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_port        <= '0;
      bus.out_port_strobe <= 1'b0;
    end else begin
      bus.out_port_strobe <= port_wr;
      if (port_wr) begin
        bus.out_port <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter
// Directed scenarios plus randomized traffic against a queue-based reference
// model. The driver pushes expected RF writes, port updates and per-cycle
// status into queues; a separate monitor pops and compares them.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int QD   = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_write_arbiter_if bus ();

  wb_write_arbiter #(
    .QDEPTH     (QD),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    bit                live;
  } aux_t;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } rf_exp_t;

  typedef struct {
    bit                stall;
    bit                ready;
    logic [DATA_W-1:0] port;
  } cyc_exp_t;

  // Reference model state.
  aux_t              m_q[$];
  int                m_age;
  bit                m_force;
  logic [DATA_W-1:0] m_port;

  // Scoreboard queues.
  rf_exp_t           rf_q[$];
  logic [DATA_W-1:0] port_q[$];
  cyc_exp_t          cyc_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_age   = 0;
    m_force = 1'b0;
    m_port  = '0;
    rf_q.delete();
    port_q.delete();
    cyc_q.delete();
  endtask

  // One cycle of the behavioural rules: who owns the RF port, which queued
  // writes become obsolete, whether the aux request is kept, starvation.
  task automatic modelStep(input bit pv, input bit psel, input bit preg, input bit pport,
                           input logic [DATA_W-1:0] pload, input logic [DATA_W-1:0] presult,
                           input logic [ADDR_W-1:0] prd, input bit av,
                           input logic [DATA_W-1:0] adata, input logic [ADDR_W-1:0] ard);
    bit                stall_now = m_force;
    bit                full      = (m_q.size() == QD);
    bit                head_live = (m_q.size() > 0) && m_q[0].live;
    bit                popped    = 1'b0;
    bit                sq_head   = 1'b0;
    bit                starving;
    bit                pw;
    bit                portw;
    logic [DATA_W-1:0] wbd;
    cyc_q.push_back('{stall_now, !full, m_port});
    wbd   = psel ? pload : presult;
    pw    = pv && preg && !pport && !stall_now;
    portw = pv && pport && !stall_now;
    if (stall_now) begin
      rf_q.push_back('{m_q[0].rd, m_q[0].data});
      void'(m_q.pop_front());
      popped = 1'b1;
    end else if (pw) begin
      rf_q.push_back('{prd, wbd});
    end else if (head_live) begin
      rf_q.push_back('{m_q[0].rd, m_q[0].data});
      void'(m_q.pop_front());
      popped = 1'b1;
    end
    if (!popped && (m_q.size() > 0) && !m_q[0].live) void'(m_q.pop_front());
    if (pw) begin
      if (head_live && !popped && (m_q[0].rd == prd)) sq_head = 1'b1;
      foreach (m_q[i]) if (m_q[i].rd == prd) m_q[i].live = 1'b0;
    end
    if (av && !full && !(pw && (ard == prd))) m_q.push_back('{ard, adata, 1'b1});
    starving = head_live && !popped && !sq_head;
    m_force  = !m_force && (m_age == SMAX) && starving;
    m_age    = starving ? ((m_age < SMAX) ? m_age + 1 : SMAX) : 0;
    if (portw) begin
      port_q.push_back(wbd);
      m_port = wbd;
    end
  endtask

  task automatic applyStimulus(input bit pv, input bit psel, input bit preg, input bit pport,
                               input logic [DATA_W-1:0] pload, input logic [DATA_W-1:0] presult,
                               input logic [ADDR_W-1:0] prd, input bit av,
                               input logic [DATA_W-1:0] adata, input logic [ADDR_W-1:0] ard);
    @(negedge clk);
    bus.p_valid      = pv;
    bus.p_wb_sel     = psel;
    bus.p_reg_write  = preg;
    bus.p_port_write = pport;
    bus.p_load       = pload;
    bus.p_result     = presult;
    bus.p_rd         = prd;
    bus.a_valid      = av;
    bus.a_data       = adata;
    bus.a_rd         = ard;
    modelStep(pv, psel, preg, pport, pload, presult, prd, av, adata, ard);
  endtask

  task automatic idleInputs();
    bus.p_valid      = 1'b0;
    bus.p_wb_sel     = 1'b0;
    bus.p_reg_write  = 1'b0;
    bus.p_port_write = 1'b0;
    bus.p_load       = '0;
    bus.p_result     = '0;
    bus.p_rd         = '0;
    bus.a_valid      = 1'b0;
    bus.a_data       = '0;
    bus.a_rd         = '0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, '0, '0, '0, 0, '0, '0);
  endtask

  task automatic applyReset(input string tag);
    @(negedge clk);
    idleInputs();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput({tag, "_out_port"}, 32'(bus.out_port), 32'h0);
    checkOutput({tag, "_strobe"}, 32'(bus.out_port_strobe), 32'h0);
    checkOutput({tag, "_a_ready"}, 32'(bus.a_ready), 32'h1);
    checkOutput({tag, "_stall"}, 32'(bus.stall), 32'h0);
    checkOutput({tag, "_rf_we"}, 32'(bus.rf_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    cyc_exp_t c;
    rf_exp_t  r;
    #2;
    if (!rst && (cyc_q.size() > 0)) begin
      c = cyc_q.pop_front();
      checkOutput("stall", 32'(bus.stall), 32'(c.stall));
      checkOutput("a_ready", 32'(bus.a_ready), 32'(c.ready));
      checkOutput("out_port_hold", 32'(bus.out_port), 32'(c.port));
      if (bus.rf_we) begin
        if (rf_q.size() == 0) begin
          checkOutput("rf_unexpected_write", 32'(bus.rf_waddr), 32'hFFFF_FFFF);
        end else begin
          r = rf_q.pop_front();
          checkOutput("rf_waddr", 32'(bus.rf_waddr), 32'(r.rd));
          checkOutput("rf_wdata", 32'(bus.rf_wdata), 32'(r.data));
        end
      end
      if (bus.out_port_strobe) begin
        if (port_q.size() == 0) begin
          checkOutput("port_unexpected_strobe", 32'(bus.out_port), 32'hFFFF_FFFF);
        end else begin
          checkOutput("out_port", 32'(bus.out_port), 32'(port_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int stall_cnt;
    idleInputs();
    modelReset();
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_out_port", 32'(bus.out_port), 32'h0);
    checkOutput("reset_a_ready", 32'(bus.a_ready), 32'h1);
    checkOutput("reset_stall", 32'(bus.stall), 32'h0);
    checkOutput("reset_rf_we", 32'(bus.rf_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load data selected for a same-cycle RF write.
    applyStimulus(1, 1, 1, 0, 16'hBEEF, 16'h1234, 3'd5, 0, '0, '0);
    #2;
    checkOutput("t1_rf_we", 32'(bus.rf_we), 32'h1);
    checkOutput("t1_rf_waddr", 32'(bus.rf_waddr), 32'h5);
    checkOutput("t1_rf_wdata", 32'(bus.rf_wdata), 32'hBEEF);

    // Port write: registered value plus one-cycle strobe, then hold.
    applyStimulus(1, 0, 0, 1, 16'hFFFF, 16'h00A5, 3'd0, 0, '0, '0);
    #2;
    checkOutput("t2_rf_we", 32'(bus.rf_we), 32'h0);
    idleCycle();
    #2;
    checkOutput("t2_port", 32'(bus.out_port), 32'h00A5);
    checkOutput("t2_strobe_hi", 32'(bus.out_port_strobe), 32'h1);
    idleCycle();
    #2;
    checkOutput("t2_hold", 32'(bus.out_port), 32'h00A5);
    checkOutput("t2_strobe_lo", 32'(bus.out_port_strobe), 32'h0);

    // Aux write drains the cycle after it is accepted.
    applyStimulus(0, 0, 0, 0, '0, '0, '0, 1, 16'h0011, 3'd2);
    idleCycle();
    #2;
    checkOutput("t3_rf_waddr", 32'(bus.rf_waddr), 32'h2);
    checkOutput("t3_rf_wdata", 32'(bus.rf_wdata), 32'h0011);
    repeat (2) idleCycle();

    // Starvation: pipeline hogs the port, two forced writes must appear.
    stall_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, 0, 1, 0, '0, 16'(16'h6000 + i), 3'd6, (i < 2),
                    (i == 0) ? 16'h0101 : 16'h0303, (i == 0) ? 3'd1 : 3'd3);
      #2;
      if (bus.stall) stall_cnt++;
    end
    checkOutput("t4_stall_cycles", 32'(stall_cnt), 32'd2);
    repeat (3) idleCycle();

    // Squash: younger pipeline write to rd 4 kills the queued aux write.
    applyStimulus(0, 0, 0, 0, '0, '0, '0, 1, 16'h4444, 3'd4);
    applyStimulus(1, 0, 1, 0, '0, 16'h5A5A, 3'd4, 0, '0, '0);
    #2;
    checkOutput("t5_rf_wdata", 32'(bus.rf_wdata), 32'h5A5A);
    repeat (4) idleCycle();

    // Reset with two queued writes and a live port value.
    applyStimulus(1, 0, 0, 1, '0, 16'h7777, 3'd0, 0, '0, '0);
    applyStimulus(1, 0, 1, 0, '0, 16'h0606, 3'd6, 1, 16'h0A01, 3'd1);
    applyStimulus(1, 0, 1, 0, '0, 16'h0607, 3'd6, 1, 16'h0A02, 3'd2);
    #2;
    checkOutput("t6_pre_port", 32'(bus.out_port), 32'h7777);
    applyReset("t6");
    repeat (6) idleCycle();

    // Randomized traffic with a narrow address range to provoke squashes.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                    16'($urandom), 16'($urandom), 3'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) == 0), 16'($urandom), 3'($urandom_range(0, 3)));
    end
    repeat (12) idleCycle();
    @(negedge clk);
    #3;
    checkOutput("rf_queue_drained", 32'(rf_q.size()), 32'd0);
    checkOutput("port_queue_drained", 32'(port_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Owns the single register-file write port and the output-port register at the end of the pipeline.
- Selects between load data and ALU result for the MEM/WB slot.
- Arbitrates the register-file write between the pipeline and an auxiliary requester (second-destination writes, e.g. SWAP/POP), which is buffered in a small queue.
- Drives a registered output port with a one-cycle update strobe, and raises a pipeline stall only when the aux head has starved.

Parameters:
DATA_W, 16, datapath width
ADDR_W, 3, register address width (8 registers)
QDEPTH, 2, aux queue depth (power of two, >=2)
STARVE_MAX, 4, cycles the aux head may wait before a forced write

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
p_valid  in  1  MEM/WB slot holds a retiring instruction
p_load  in  DATA_W  memory load data
p_result  in  DATA_W  ALU/Rd result
p_wb_sel  in  1  1 = p_load, 0 = p_result
p_reg_write  in  1  instruction writes a register
p_port_write  in  1  instruction writes the output port
p_rd  in  ADDR_W  destination register
a_valid  in  1  aux write request
a_data  in  DATA_W  aux write data
a_rd  in  ADDR_W  aux destination
a_ready  out  1  aux request accepted this cycle (= queue not full)
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
out_port  out  DATA_W  output port value (registered)
out_port_strobe  out  1  one-cycle pulse, out_port updated
stall  out  1  upstream must hold the MEM/WB slot this cycle

Behaviour:
- Reset (async):
  - Queue empty; age counter 0; FSM state NORMAL.
  - out_port = 0, out_port_strobe = 0.
  - Combinational outputs at reset: rf_we = 0, stall = 0, a_ready = 1.
- Writeback data: wb_data = p_wb_sel ? p_load : p_result.
- Pipeline write: pw = p_valid & p_reg_write & ~p_port_write & ~stall.
- Port write: p_valid & p_port_write & ~stall
  - out_port <= wb_data next edge; out_port_strobe = 1 for that cycle.
  - No register-file write.
  - out_port otherwise holds its value; no latch.
- Register-file port (combinational, same cycle):
  - FSM FORCE: write the queue head; pop.
  - Else if pw: write p_rd / wb_data.
  - Else if queue non-empty: write the head; pop.
  - Else rf_we = 0.
- Aux queue:
  - FIFO of {rd, data}; a_ready = ~full; enqueue on a_valid & a_ready.
  - No bypass: an entry enqueued in cycle N is poppable from N+1 at the earliest.
  - Enqueue and pop in the same cycle are legal; occupancy is unchanged.
  - Pointers wrap modulo QDEPTH.
- Squash rule (aux writes are program-older than the retiring pipeline instruction):
  - When pw with address X, every queued entry with rd == X is invalidated and skipped.
  - A same-cycle incoming aux request with a_rd == X is accepted (a_ready stays high) and discarded.
  - Invalidated entries are skipped silently and never drive rf_we.
- Age counter:
  - Cleared on pop, squash of the head, or empty queue.
  - Otherwise increments each cycle a valid head is not popped; saturates at STARVE_MAX.
- FSM:
  - NORMAL -> FORCE when age == STARVE_MAX.
  - FORCE lasts exactly one cycle: stall = 1, head popped, then -> NORMAL.
  - stall is driven only from the registered state; no combinational input-to-stall path.
- Reset mid-operation: queued aux writes are lost, the FSM returns to NORMAL, out_port clears. Requesters must reissue.

Decomposition:
- Shared package: DATA_W, ADDR_W, and a wb_entry_t struct {rd, data, valid}.
- One sub-module, wb_aux_fifo: queue, squash compare and valid bits.
- Arbitration, FSM, age counter and output-port register stay in the top level.

Test Plan:
1. p_valid=1, p_reg_write=1, p_wb_sel=1, p_load=16'hBEEF, p_result=16'h1234, p_rd=5 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=16'hBEEF; a_ready=1.
2. p_port_write=1, p_wb_sel=0, p_result=16'h00A5 -> next edge out_port=16'h00A5 with strobe high 1 cycle, rf_we=0; the following idle cycle out_port holds 16'h00A5, strobe=0.
3. Aux enqueue (rd=2, 16'h0011) with the pipeline idle -> rf_we=1, rf_waddr=2, rf_wdata=16'h0011 the next cycle; queue empty after; stall never asserted.
4. Queue 2 aux entries (rd=1, rd=3), then pipeline writes every cycle to rd=6 -> age reaches 4 -> one cycle stall=1 with rf_waddr=1; a_ready=0 while full; second entry forced after another 4 cycles.
5. Aux rd=4 queued, pipeline writes rd=4 next cycle -> entry squashed; rf_wdata is the pipeline value and rd=4 is never written by aux.
6. Assert rst with 2 entries queued and out_port=16'h7777 -> immediately out_port=0, a_ready=1, stall=0; no aux writes after release.
